control_unit: RTL and testbench
===============================

# control_unit

- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Drives the program counter's `load_PC`/`incr_PC` controls, the instruction and operand register loads, the accumulator/ALU controls, and a req/ack memory handshake.
- The datapath routes the operand register to the PC's `addr` input.
- The memory address mux selects the PC or the operand register under `addr_sel`.

## Interface
- `TIMEOUT`, default 15: cycles `mem_req` may stay high without `mem_ack` before FAULT. Legal range 1..255. Used only with `CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ir`  in  8  instruction register contents; opcode = `ir[7:4]`.
- `zero`  in  1  accumulator-zero flag from the datapath.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `load_PC`  out  1  load PC from operand register.
- `incr_PC`  out  1  increment PC.
- `load_IR`  out  1  capture memory read data into IR.
- `load_OPR`  out  1  capture memory read data into operand register.
- `load_ACC`  out  1  write ALU result into accumulator.
- `alu_op`  out  2  00 pass, 01 add, 10 sub, 11 unused.
- `addr_sel`  out  1  0 = PC drives memory address, 1 = operand register.
- `mem_req`  out  1  memory request; held until acknowledged.
- `mem_we`  out  1  write qualifier, valid while `mem_req` = 1.
- `halted`  out  1  HALT state.
- `fault`  out  1  FAULT state.
- `state`  out  3  encoding: FETCH=0, DECODE=1, OPFETCH=2, EXEC=3, HALT=4, FAULT=5.

## Operation
Opcodes:
- 0 NOP
- 1 LOAD a
- 2 STORE a
- 3 ADD a
- 4 SUB a
- 5 JMP a
- 6 JZ a
- F HALT
- 7–E: undefined, executed as NOP.

Opcodes 1–6 are two-word instructions; operand `a` is the next memory word.

State behaviour:
- **FETCH:** `addr_sel`=0, `mem_req`=1.
  - On `mem_ack`: `load_IR`=1 and `incr_PC`=1 in the same cycle, then go to DECODE.
- **DECODE:** all outputs 0.
  - Opcodes 1–6 go to OPFETCH.
  - Opcode F goes to HALT.
  - All others go to FETCH.
- **OPFETCH:** `addr_sel`=0, `mem_req`=1.
  - On `mem_ack`: `load_OPR`=1 and `incr_PC`=1, then go to EXEC.
- **EXEC**, by opcode:
  - LOAD/ADD/SUB: `addr_sel`=1, `mem_req`=1. On `mem_ack`: `load_ACC`=1 with `alu_op` 00/01/10, then go to FETCH.
  - STORE: `addr_sel`=1, `mem_req`=1, `mem_we`=1. On `mem_ack`, go to FETCH.
  - JMP: `load_PC`=1 for one cycle, then go to FETCH.
  - JZ: `load_PC`=`zero` for one cycle, then go to FETCH.
- **HALT:** `halted`=1, all other outputs 0. Terminal until reset.
- **FAULT:** `fault`=1, all other outputs 0. Terminal until reset.

Invariants:
- `load_PC` and `incr_PC` are never high in the same cycle.
- `mem_we` is 0 whenever `mem_req` is 0.
- `ir` is sampled only in DECODE and EXEC.
- `mem_ack` is ignored while `mem_req` = 0.

## Timing
- All outputs are Moore/Mealy combinational decodes of registered state plus `mem_ack`/`zero`/`ir`. There is no added output register.
- With zero-wait memory (`mem_ack` high in the first request cycle):
  - NOP/undefined: 2 cycles.
  - HALT: reaches HALT 2 cycles after entering FETCH.
  - LOAD/STORE/ADD/SUB: 4 cycles.
  - JMP/JZ: 4 cycles.
- Each wait cycle without `mem_ack` adds one cycle. State and all request outputs hold stable while waiting.
- Reset (`reset`=0):
  - State = FETCH.
  - All outputs drop to 0 asynchronously, including mid-handshake (`mem_req` may fall without ack).
  - The timeout counter clears.
- After reset deasserts, `mem_req` rises in the first FETCH cycle, combinationally.

## Configuration
`CTRL_TIMEOUT_EN` defined:
- An 8-bit wait counter clears on entry to every request state and on `mem_ack`.
- It increments each cycle `mem_req`=1 and `mem_ack`=0.
- When the counter equals `TIMEOUT` with `mem_ack` still 0, the next edge enters FAULT.
- `mem_ack` arriving in the same cycle the counter hits `TIMEOUT` wins: the handshake completes normally.

`CTRL_TIMEOUT_EN` undefined:
- No counter; the block waits indefinitely.
- FAULT is unreachable and `fault` is tied 0.
- The `TIMEOUT` parameter is unused.

## Test plan
- **Reset:** hold `reset`=0 → state=0, every output 0. Release with `mem_ack`=1, `ir`=0x00 → `load_IR`+`incr_PC` in cycle 1, DECODE in cycle 2, FETCH in cycle 3.
- **LOAD:** `ir`=0x1_, zero-wait memory → OPFETCH pulses `load_OPR`+`incr_PC`. EXEC asserts `addr_sel`=1, `load_ACC`=1, `alu_op`=00. Back in FETCH after 4 cycles.
- **STORE with wait states:** `ir`=0x2_, `mem_ack` delayed 3 cycles in EXEC → `mem_req`=`mem_we`=`addr_sel`=1 held stable for 4 cycles. `load_ACC` never asserts.
- **JZ:** `ir`=0x6_ with `zero`=1 → `load_PC`=1 for exactly one EXEC cycle, `incr_PC`=0 that cycle. Repeat with `zero`=0 → `load_PC` stays 0.
- **HALT and mid-handshake reset:** `ir`=0xF0 → `halted`=1 indefinitely despite `mem_ack` toggling. Separately, assert `reset` mid-OPFETCH → `mem_req` drops in the same cycle and state=0.
- **Timeout (`CTRL_TIMEOUT_EN`, `TIMEOUT`=4):** `mem_ack` held 0 in FETCH → `fault`=1 and state=5 after `mem_req` has been high for 5 cycles. Ack arriving on cycle 5 instead → normal DECODE.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives PC, IR, operand register and accumulator controls, and runs a
// req/ack handshake to memory.
//
// Optional build macro: CTRL_TIMEOUT_EN
//   defined   - an 8-bit wait counter sends the FSM to FAULT when mem_req has
//               been held TIMEOUT+1 cycles without mem_ack.
//   undefined - the FSM waits indefinitely; fault is tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | request instruction word at PC; on ack load IR, bump PC
// DECODE  | inspect opcode, choose operand fetch / halt / next fetch
// OPFETCH | request operand word at PC; on ack load OPR, bump PC
// EXEC    | memory access at OPR (LOAD/ADD/SUB/STORE) or PC load (JMP/JZ)
// HALT    | terminal until reset
// FAULT   | handshake timeout, terminal until reset
module control_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       load_PC,
  output logic       incr_PC,
  output logic       load_IR,
  output logic       load_OPR,
  output logic       load_ACC,
  output logic [1:0] alu_op,
  output logic       addr_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPFETCH = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("control_unit: TIMEOUT must be in 1..255");
  end

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [3:0] opcode;
  logic       unused_ir_low;

  logic       lpc_c;
  logic       ipc_c;
  logic       lir_c;
  logic       lopr_c;
  logic       lacc_c;
  logic [1:0] alu_c;
  logic       asel_c;
  logic       req_c;
  logic       we_c;

  assign opcode        = ir[7:4];
  assign unused_ir_low = ^ir[3:0];

`ifdef CTRL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] wait_q;
  logic       timed_out;

  // A request that reaches the limit without ack abandons the handshake.
  assign timed_out = req_c && !mem_ack && (wait_q == TIMEOUT_CNT);
`endif

  // Next-state and output decode from registered state plus ack/zero/opcode.
  always_comb begin
    state_d = state_q;
    lpc_c   = 1'b0;
    ipc_c   = 1'b0;
    lir_c   = 1'b0;
    lopr_c  = 1'b0;
    lacc_c  = 1'b0;
    alu_c   = 2'b00;
    asel_c  = 1'b0;
    req_c   = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          lir_c   = 1'b1;
          ipc_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode >= OP_LOAD && opcode <= OP_JZ) state_d = S_OPFETCH;
        else if (opcode == OP_HALT)               state_d = S_HALT;
        else                                      state_d = S_FETCH;
      end
      S_OPFETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          lopr_c  = 1'b1;
          ipc_c   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB: begin
            asel_c = 1'b1;
            req_c  = 1'b1;
            if (mem_ack) begin
              lacc_c  = 1'b1;
              alu_c   = (opcode == OP_ADD) ? 2'b01 :
                        (opcode == OP_SUB) ? 2'b10 : 2'b00;
              state_d = S_FETCH;
            end
          end
          OP_STORE: begin
            asel_c = 1'b1;
            req_c  = 1'b1;
            we_c   = 1'b1;
            if (mem_ack) state_d = S_FETCH;
          end
          OP_JMP: begin
            lpc_c   = 1'b1;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            lpc_c   = zero;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
`ifdef CTRL_TIMEOUT_EN
    if (timed_out) state_d = S_FAULT;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef CTRL_TIMEOUT_EN
  // Wait counter: restarts on every state change and on ack, counts stalled request cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          wait_q <= 8'd0;
    else if (state_d != state_q)         wait_q <= 8'd0;
    else if (req_c && mem_ack)           wait_q <= 8'd0;
    else if (req_c)                      wait_q <= wait_q + 8'd1;
  end

  assign fault = (state_q == S_FAULT) && reset;
`else
  assign fault = 1'b0;
`endif

  // Outputs are gated by reset so an in-flight request drops immediately.
  assign load_PC  = lpc_c  & reset;
  assign incr_PC  = ipc_c  & reset;
  assign load_IR  = lir_c  & reset;
  assign load_OPR = lopr_c & reset;
  assign load_ACC = lacc_c & reset;
  assign alu_op   = alu_c  & {2{reset}};
  assign addr_sel = asel_c & reset;
  assign mem_req  = req_c  & reset;
  assign mem_we   = we_c   & reset;
  assign halted   = (state_q == S_HALT) && reset;
  assign state    = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: each instruction is expanded into an
// expected per-cycle output trace from the opcode rules, then played against
// the DUT with randomized wait states and stray acks.
module tb_control_unit;

`ifdef CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TB_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       load_PC, incr_PC, load_IR, load_OPR, load_ACC;
  logic [1:0] alu_op;
  logic       addr_sel, mem_req, mem_we, halted, fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ack;
    logic [14:0] exp;
  } ent_t;
  ent_t q[$];

  control_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ir(ir), .zero(zero), .mem_ack(mem_ack),
    .load_PC(load_PC), .incr_PC(incr_PC), .load_IR(load_IR),
    .load_OPR(load_OPR), .load_ACC(load_ACC), .alu_op(alu_op),
    .addr_sel(addr_sel), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] mk(input logic [2:0] st, input logic lpc, ipc, lir, lopr, lacc,
                                     input logic [1:0] alu, input logic asel, req, we, hlt, flt);
    return {st, lpc, ipc, lir, lopr, lacc, alu, asel, req, we, hlt, flt};
  endfunction

  function automatic logic [14:0] obs();
    return {state, load_PC, incr_PC, load_IR, load_OPR, load_ACC, alu_op,
            addr_sel, mem_req, mem_we, halted, fault};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One memory request phase: w stalled cycles, then the ack cycle, or a
  // timeout into FAULT when the stall outlasts the limit.
  task automatic req_phase(input logic [2:0] st, input logic asel, we, lir, lopr, ipc, lacc,
                           input logic [1:0] alu, input int w, output bit flt);
    int stall;
    flt   = TO_EN && (w > TB_TIMEOUT);
    stall = flt ? TB_TIMEOUT + 1 : w;
    for (int i = 0; i < stall; i++)
      q.push_back({1'b0, mk(st, 0, 0, 0, 0, 0, 2'b00, asel, 1, we, 0, 0)});
    if (flt) begin
      for (int i = 0; i < 4; i++)
        q.push_back({rbit(), mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1)});
    end else begin
      q.push_back({1'b1, mk(st, 0, ipc, lir, lopr, lacc, alu, asel, 1, we, 0, 0)});
    end
  endtask

  task automatic play(input string tag);
    ent_t e;
    int   idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ack = e.ack;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, idx), obs(), e.exp);
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  // Expected trace of one instruction starting in FETCH.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] lo,
                           input logic z, input int wf, wo, wx);
    bit f;
    q.delete();
    req_phase(3'd0, 0, 0, 1, 0, 1, 0, 2'b00, wf, f);
    if (!f) begin
      q.push_back({rbit(), mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)});
      if (op >= 4'h1 && op <= 4'h6) begin
        req_phase(3'd2, 0, 0, 0, 1, 1, 0, 2'b00, wo, f);
        if (!f) begin
          case (op)
            4'h1: req_phase(3'd3, 1, 0, 0, 0, 0, 1, 2'b00, wx, f);
            4'h3: req_phase(3'd3, 1, 0, 0, 0, 0, 1, 2'b01, wx, f);
            4'h4: req_phase(3'd3, 1, 0, 0, 0, 0, 1, 2'b10, wx, f);
            4'h2: req_phase(3'd3, 1, 1, 0, 0, 0, 0, 2'b00, wx, f);
            4'h5: q.push_back({rbit(), mk(3'd3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)});
            default: q.push_back({rbit(), mk(3'd3, z, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)});
          endcase
        end
      end else if (op == 4'hF) begin
        for (int i = 0; i < 6; i++)
          q.push_back({rbit(), mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0)});
      end
    end
    ir   = {op, lo};
    zero = z;
    play(tag);
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
  task automatic do_reset(input string tag);
    #1;
    reset   = 1'b0;
    mem_ack = rbit();
    #1;
    check(tag, obs(), 15'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    // Reset held: everything low even with ack and an instruction present.
    reset   = 1'b0;
    mem_ack = 1'b1;
    ir      = 8'hF0;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", obs(), 15'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr("reset_nop", 4'h0, 4'h0, 0, 0, 0, 0);

    run_instr("load",      4'h1, 4'h5, 0, 0, 0, 0);
    run_instr("add",       4'h3, 4'h1, 0, 0, 0, 0);
    run_instr("sub",       4'h4, 4'h2, 1, 0, 0, 0);
    run_instr("store_ws",  4'h2, 4'h9, 0, 0, 0, 3);
    run_instr("jz_taken",  4'h6, 4'h0, 1, 0, 0, 0);
    run_instr("jz_not",    4'h6, 4'h0, 0, 0, 0, 0);
    run_instr("jmp",       4'h5, 4'h3, 0, 0, 0, 0);
    run_instr("undef",     4'hA, 4'h7, 0, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 14));
      run_instr($sformatf("rand%0d_op%0h", n, op), op, 4'($urandom_range(0, 15)), rbit(),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Ack on the last allowed stall cycle completes normally.
    run_instr("ack_at_limit", 4'h1, 4'h0, 0, TB_TIMEOUT, TB_TIMEOUT, TB_TIMEOUT);
    // Longer stall: FAULT when the timeout is built in, plain wait otherwise.
    run_instr("long_stall", 4'h0, 4'h0, 0, TO_EN ? TB_TIMEOUT + 1 : 12, 0, 0);
    do_reset("reset_after_stall");
    run_instr("post_stall", 4'h3, 4'h0, 0, 1, 0, TO_EN ? TB_TIMEOUT + 2 : 9);
    do_reset("reset_after_exec_stall");

    // Reset while waiting in OPFETCH.
    q.delete();
    q.push_back({1'b1, mk(3'd0, 0, 1, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0)});
    q.push_back({1'b0, mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)});
    q.push_back({1'b0, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0)});
    ir = 8'h14;
    play("mid_opfetch");
    mem_ack = 1'b0;
    @(negedge clk);
    check("opfetch_waiting", obs(), mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check("opfetch_reset", obs(), 15'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr("after_mid_reset", 4'h2, 4'h0, 0, 0, 1, 0);

    run_instr("halt", 4'hF, 4'h0, 0, 0, 0, 0);
    do_reset("reset_from_halt");
    run_instr("final_nop", 4'h0, 4'h0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
